// File: rtl/kernel_c_vout_reduce.sv
// Frame reducer: sums each run of NELEM input words and presents one registered
// sum per frame on a valid/ready output, with no bubble across frame boundaries.
module kernel_c_vout_reduce #(
  parameter int STREAMW = 32,
  parameter int NELEM   = 1024,
  parameter int SUMW    = 42
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STREAMW-1:0] in1_s0,
  input  logic               ivalid,
  output logic               iready,
  output logic [SUMW-1:0]    out1_s0,
  output logic               ovalid,
  input  logic               oready,
  output logic [15:0]        frame_idx
);

  localparam int CNTW = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NELEM - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state_q, state_d;
  logic [SUMW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [SUMW-1:0]   out_q, out_d;
  logic [15:0]       fidx_q, fidx_d;

  logic              accept;
  logic              xfer;
  logic [SUMW-1:0]   sum;

  // A pending sum only blocks input while downstream is not taking it.
  assign iready    = (state_q == ACCUM) | oready;
  assign ovalid    = (state_q == HOLD);
  assign out1_s0   = out_q;
  assign frame_idx = fidx_q;

  assign accept = ivalid & iready;
  assign xfer   = ovalid & oready;
  assign sum    = acc_q + SUMW'(in1_s0);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    fidx_d  = fidx_q;

    if (xfer) begin
      state_d = ACCUM;
    end

    // A same-cycle accept that completes a frame overrides the drain above.
    if (accept) begin
      if (cnt_q == LAST_CNT) begin
        out_d   = sum;
        acc_d   = '0;
        cnt_d   = '0;
        fidx_d  = fidx_q + 16'd1;
        state_d = HOLD;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      fidx_q  <= fidx_d;
    end
  end

endmodule

// File: tb/tb_kernel_c_vout_reduce.sv
// Directed table for the NELEM=4 reducer, width-wrap checks, and a randomized
// NELEM=1 pass-through run against a queue scoreboard.
module tb_kernel_c_vout_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance A: NELEM=4, STREAMW=32, SUMW=42
  logic        a_rst = 1'b0, a_iv = 1'b0, a_ordy = 1'b0;
  logic [31:0] a_din = '0;
  logic        a_irdy, a_ov;
  logic [41:0] a_out;
  logic [15:0] a_fidx;

  kernel_c_vout_reduce #(.STREAMW(32), .NELEM(4), .SUMW(42)) u_a (
    .clk(clk), .rst(a_rst), .in1_s0(a_din), .ivalid(a_iv), .iready(a_irdy),
    .out1_s0(a_out), .ovalid(a_ov), .oready(a_ordy), .frame_idx(a_fidx));

  // Instances B/C: 8-bit words, SUMW=9 and SUMW=8, shared stimulus
  logic       bc_rst = 1'b0, bc_iv = 1'b0, bc_ordy = 1'b0;
  logic [7:0] bc_din = '0;
  logic       b_irdy, b_ov, c_irdy, c_ov;
  logic [8:0] b_out;
  logic [7:0] c_out;
  logic [15:0] b_fidx, c_fidx;

  kernel_c_vout_reduce #(.STREAMW(8), .NELEM(4), .SUMW(9)) u_b (
    .clk(clk), .rst(bc_rst), .in1_s0(bc_din), .ivalid(bc_iv), .iready(b_irdy),
    .out1_s0(b_out), .ovalid(b_ov), .oready(bc_ordy), .frame_idx(b_fidx));

  kernel_c_vout_reduce #(.STREAMW(8), .NELEM(4), .SUMW(8)) u_c (
    .clk(clk), .rst(bc_rst), .in1_s0(bc_din), .ivalid(bc_iv), .iready(c_irdy),
    .out1_s0(c_out), .ovalid(c_ov), .oready(bc_ordy), .frame_idx(c_fidx));

  // Instance D: NELEM=1 pass-through, 16-bit words zero-extended to 20
  logic        d_rst = 1'b0, d_iv = 1'b0, d_ordy = 1'b0;
  logic [15:0] d_din = '0;
  logic        d_irdy, d_ov;
  logic [19:0] d_out;
  logic [15:0] d_fidx;

  kernel_c_vout_reduce #(.STREAMW(16), .NELEM(1), .SUMW(20)) u_d (
    .clk(clk), .rst(d_rst), .in1_s0(d_din), .ivalid(d_iv), .iready(d_irdy),
    .out1_s0(d_out), .ovalid(d_ov), .oready(d_ordy), .frame_idx(d_fidx));

  typedef struct packed {
    logic        rst_n;
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [41:0] e_out;
    logic [15:0] e_fidx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst_n, input logic iv, input logic [31:0] din,
                     input logic ordy, input logic e_irdy, input logic e_ov,
                     input logic [41:0] e_out, input logic [15:0] e_fidx);
    vec_t v;
    v.rst_n = rst_n; v.iv = iv; v.din = din; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_out = e_out; v.e_fidx = e_fidx;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int accepted;
    int cycles;
    logic [19:0] sb[$];
    logic [19:0] exp_w;

    // Expected outputs of each row are the values visible before that row's edge.
    //   rst iv din ordy | irdy ov out fidx
    add(0, 0, 0, 1,  1, 0,  0, 0);
    add(1, 1, 1, 1,  1, 0,  0, 0);
    add(1, 1, 2, 1,  1, 0,  0, 0);
    add(1, 1, 3, 1,  1, 0,  0, 0);
    add(1, 1, 4, 1,  1, 0,  0, 0);
    add(1, 1, 5, 1,  1, 1, 10, 1);   // first sum, next frame starts with no bubble
    add(1, 1, 6, 1,  1, 0, 10, 1);
    add(1, 1, 7, 1,  1, 0, 10, 1);
    add(1, 1, 8, 1,  1, 0, 10, 1);
    add(1, 0, 0, 1,  1, 1, 26, 2);
    add(1, 0, 0, 1,  1, 0, 26, 2);
    // stall: words 1..4 with oready low, then five held cycles with word 9 offered
    add(1, 1, 1, 0,  1, 0, 26, 2);
    add(1, 1, 2, 0,  1, 0, 26, 2);
    add(1, 1, 3, 0,  1, 0, 26, 2);
    add(1, 1, 4, 0,  1, 0, 26, 2);
    for (int i = 0; i < 5; i++) add(1, 1, 9, 0,  0, 1, 10, 3);
    add(1, 1, 9, 1,  1, 1, 10, 3);   // release: 9 accepted with the transfer
    add(1, 0, 0, 1,  1, 0, 10, 3);
    add(1, 1, 1, 1,  1, 0, 10, 3);   // 9+1+1+1 proves cnt was 1
    add(1, 1, 1, 1,  1, 0, 10, 3);
    add(1, 1, 1, 1,  1, 0, 10, 3);
    add(1, 0, 0, 0,  0, 1, 12, 4);
    add(1, 0, 0, 1,  1, 1, 12, 4);
    add(1, 0, 0, 1,  1, 0, 12, 4);
    // reset mid-frame discards 7+7
    add(1, 1, 7, 1,  1, 0, 12, 4);
    add(1, 1, 7, 1,  1, 0, 12, 4);
    add(0, 0, 0, 1,  1, 0,  0, 0);
    add(1, 1, 5, 1,  1, 0,  0, 0);
    add(1, 1, 5, 1,  1, 0,  0, 0);
    add(1, 1, 5, 1,  1, 0,  0, 0);
    add(1, 1, 5, 1,  1, 0,  0, 0);
    add(1, 0, 0, 1,  1, 1, 20, 1);
    add(1, 0, 0, 1,  1, 0, 20, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      a_rst = tbl[i].rst_n; a_iv = tbl[i].iv; a_din = tbl[i].din; a_ordy = tbl[i].ordy;
      #1;
      chk($sformatf("a_iready[%0d]", i), 64'(a_irdy), 64'(tbl[i].e_irdy));
      chk($sformatf("a_ovalid[%0d]", i), 64'(a_ov), 64'(tbl[i].e_ov));
      chk($sformatf("a_out[%0d]", i), 64'(a_out), 64'(tbl[i].e_out));
      chk($sformatf("a_fidx[%0d]", i), 64'(a_fidx), 64'(tbl[i].e_fidx));
    end

    // Width wrap: four 0xFF words
    @(negedge clk);
    bc_rst = 1'b1; bc_iv = 1'b1; bc_din = 8'hFF; bc_ordy = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    @(negedge clk);
    bc_iv = 1'b0; bc_din = 8'h00;
    #1;
    chk("b_ovalid", 64'(b_ov), 64'd1);
    chk("b_sum9", 64'(b_out), 64'h1FC);
    chk("c_ovalid", 64'(c_ov), 64'd1);
    chk("c_sum8_wrap", 64'(c_out), 64'hFC);
    chk("b_fidx", 64'(b_fidx), 64'd1);
    @(negedge clk);
    #1;
    chk("b_ovalid_one_cycle", 64'(b_ov), 64'd0);
    chk("c_ovalid_one_cycle", 64'(c_ov), 64'd0);

    // NELEM=1 randomized pass-through
    @(negedge clk);
    d_rst = 1'b1;
    accepted = 0;
    cycles = 0;
    while (accepted < 1000 || sb.size() > 0) begin
      @(negedge clk);
      d_iv   = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      d_ordy = 1'($urandom_range(0, 1));
      d_din  = 16'($urandom);
      #1;
      if (d_ov && d_ordy) begin
        if (sb.size() == 0) begin
          chk("d_spurious_output", 64'(d_out), 64'hDEAD_0000);
        end else begin
          exp_w = sb.pop_front();
          chk("d_passthru", 64'(d_out), 64'(exp_w));
        end
      end
      if (d_iv && d_irdy) begin
        sb.push_back(20'(d_din));
        accepted++;
      end
      cycles++;
      if (cycles > 20000) begin
        chk("d_cycle_budget", 64'(cycles), 64'd20000);
        break;
      end
    end
    @(negedge clk);
    d_iv = 1'b0; d_ordy = 1'b0;
    #1;
    chk("d_no_duplicate", 64'(d_ov), 64'd0);
    chk("d_fidx", 64'(d_fidx), 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
